// File: rtl/updown_bound_counter_if.sv
// Control/status bundle for updown_bound_counter: stepping controls, bounds and counter outputs.
// The master drives the controls and observes the count; the counter owns the slave side.
interface updown_bound_counter_if #(
  parameter int COUNT_BIT = 8,
  parameter int STEP_BIT  = 4
);
  logic                 clr;
  logic                 load;
  logic [COUNT_BIT-1:0] load_val;
  logic                 en;
  logic                 mode;
  logic [STEP_BIT-1:0]  step;
  logic [COUNT_BIT-1:0] lim_lo;
  logic [COUNT_BIT-1:0] lim_hi;
  logic                 wrap;
  logic [COUNT_BIT-1:0] cnt_o;
  logic                 tc_o;
  logic                 at_hi_o;
  logic                 at_lo_o;

  modport master (
    output clr, load, load_val, en, mode, step, lim_lo, lim_hi, wrap,
    input  cnt_o, tc_o, at_hi_o, at_lo_o
  );

  modport slave (
    input  clr, load, load_val, en, mode, step, lim_lo, lim_hi, wrap,
    output cnt_o, tc_o, at_hi_o, at_lo_o
  );
endinterface

// File: rtl/updown_bound_counter.sv
// Up/down counter with programmable step and inclusive bounds, wrap or saturate on crossing,
// and a registered terminal-count pulse aligned with the count update that caused it.
module updown_bound_counter #(
  parameter int COUNT_BIT = 8,
  parameter int STEP_BIT  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  updown_bound_counter_if.slave bus
);

  logic [COUNT_BIT-1:0] cnt_q, cnt_d;
  logic                 tc_q, tc_d;
  logic [COUNT_BIT:0]   step_x;
  logic [COUNT_BIT:0]   sum_up;
  logic [COUNT_BIT:0]   diff_dn;
  logic                 evt_up;
  logic                 evt_dn;

  // One extra bit on both paths: carry out of the sum and borrow out of the difference
  // both count as crossing, so no aliasing at the ends of the range.
  assign step_x  = {{(COUNT_BIT + 1 - STEP_BIT){1'b0}}, bus.step};
  assign sum_up  = {1'b0, cnt_q} + step_x;
  assign diff_dn = {1'b0, cnt_q} - step_x;
  assign evt_up  = sum_up > {1'b0, bus.lim_hi};
  assign evt_dn  = diff_dn[COUNT_BIT] || (diff_dn[COUNT_BIT-1:0] < bus.lim_lo);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.mode) begin
        if (evt_up) begin
          cnt_d = bus.wrap ? bus.lim_lo : bus.lim_hi;
          tc_d  = 1'b1;
        end else begin
          cnt_d = sum_up[COUNT_BIT-1:0];
        end
      end else begin
        if (evt_dn) begin
          cnt_d = bus.wrap ? bus.lim_hi : bus.lim_lo;
          tc_d  = 1'b1;
        end else begin
          cnt_d = diff_dn[COUNT_BIT-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.cnt_o   = cnt_q;
  assign bus.tc_o    = tc_q;
  assign bus.at_hi_o = (cnt_q == bus.lim_hi);
  assign bus.at_lo_o = (cnt_q == bus.lim_lo);

endmodule

// File: tb/tb_updown_bound_counter.sv
// Bench for updown_bound_counter: integer reference model checked every falling edge,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_updown_bound_counter;
  localparam int CB = 4;
  localparam int SB = 2;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;
  int   m_tc    = 0;

  updown_bound_counter_if #(.COUNT_BIT(CB), .STEP_BIT(SB)) bus ();

  updown_bound_counter #(.COUNT_BIT(CB), .STEP_BIT(SB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic on the values present at the edge.
  always @(posedge clk or negedge rst_n) begin
    int lo, hi, st, nxt;
    if (!rst_n) begin
      m_cnt = 0;
      m_tc  = 0;
    end else begin
      lo = int'(bus.lim_lo);
      hi = int'(bus.lim_hi);
      st = int'(bus.step);
      m_tc = 0;
      if (bus.clr) m_cnt = 0;
      else if (bus.load) m_cnt = int'(bus.load_val);
      else if (bus.en) begin
        nxt = bus.mode ? m_cnt + st : m_cnt - st;
        if (bus.mode && nxt > hi) begin
          m_cnt = bus.wrap ? lo : hi;
          m_tc  = 1;
        end else if (!bus.mode && nxt < lo) begin
          m_cnt = bus.wrap ? hi : lo;
          m_tc  = 1;
        end else begin
          m_cnt = nxt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_cnt", int'(bus.cnt_o), m_cnt);
      chk("model_tc", int'(bus.tc_o), m_tc);
      chk("model_at_hi", int'(bus.at_hi_o), int'(m_cnt == int'(bus.lim_hi)));
      chk("model_at_lo", int'(bus.at_lo_o), int'(m_cnt == int'(bus.lim_lo)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int lo, input int hi, input int st, input int wr);
    bus.lim_lo = CB'(lo);
    bus.lim_hi = CB'(hi);
    bus.step   = SB'(st);
    bus.wrap   = wr[0];
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = CB'(v);
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic expect_step(input string name, input int c, input int t);
    cyc();
    chk({name, "_cnt"}, int'(bus.cnt_o), c);
    chk({name, "_tc"}, int'(bus.tc_o), t);
  endtask

  initial begin
    int held;
    rst_n        = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    bus.mode     = 1'b1;
    setup(0, 15, 1, 0);
    repeat (3) cyc();
    chk("reset_cnt", int'(bus.cnt_o), 0);
    chk("reset_tc", int'(bus.tc_o), 0);
    rst_n = 1'b1;
    cyc();

    // Reset mid-count
    do_load(4);
    bus.en = 1'b1;
    expect_step("pre_reset", 5, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_cnt", int'(bus.cnt_o), 0);
    chk("async_reset_tc", int'(bus.tc_o), 0);
    rst_n = 1'b1;
    expect_step("post_reset", 1, 0);
    bus.en = 1'b0;

    // Up wrap
    setup(2, 9, 3, 1);
    do_load(2);
    chk("wrap_load_at_lo", int'(bus.at_lo_o), 1);
    bus.en = 1'b1; bus.mode = 1'b1;
    expect_step("wrap_a", 5, 0);
    expect_step("wrap_b", 8, 0);
    expect_step("wrap_c", 2, 1);
    chk("wrap_at_lo", int'(bus.at_lo_o), 1);
    expect_step("wrap_d", 5, 0);
    bus.en = 1'b0;

    // Down saturate
    setup(3, 12, 2, 0);
    do_load(6);
    bus.en = 1'b1; bus.mode = 1'b0;
    expect_step("sat_a", 4, 0);
    expect_step("sat_b", 3, 1);
    expect_step("sat_c", 3, 1);
    chk("sat_at_lo", int'(bus.at_lo_o), 1);
    bus.en = 1'b0;

    // Full-range carry
    setup(0, 15, 1, 1);
    do_load(14);
    bus.en = 1'b1; bus.mode = 1'b1;
    expect_step("full_a", 15, 0);
    expect_step("full_b", 0, 1);
    bus.mode = 1'b0;
    expect_step("full_c", 15, 1);
    bus.en = 1'b0;

    // Priority
    setup(0, 9, 1, 1);
    do_load(7);
    bus.clr = 1'b1; bus.load = 1'b1; bus.en = 1'b1; bus.mode = 1'b1;
    bus.load_val = CB'(5);
    expect_step("prio_clr", 0, 0);
    bus.clr = 1'b0; bus.load_val = CB'(9);
    expect_step("prio_load", 9, 0);
    bus.load = 1'b0; bus.en = 1'b0;

    // Hold cases
    held = int'(bus.cnt_o);
    for (int i = 0; i < 5; i++) expect_step("hold_en0", held, 0);
    bus.en = 1'b1; bus.step = '0;
    expect_step("hold_step0", 9, 0);
    chk("hold_at_hi", int'(bus.at_hi_o), 1);
    bus.en = 1'b0;

    // Randomized
    for (int i = 0; i < 3000; i++) begin
      int lo, hi, tmp;
      lo = int'($urandom_range(0, 15));
      hi = int'($urandom_range(0, 15));
      if (lo > hi && $urandom_range(0, 9) != 0) begin
        tmp = lo; lo = hi; hi = tmp;
      end
      setup(lo, hi, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      bus.clr      = ($urandom_range(0, 39) == 0);
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.load_val = CB'($urandom_range(0, 15));
      bus.en       = ($urandom_range(0, 9) < 7);
      bus.mode     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
